serial_frame_rx: RTL and testbench

Serial-in/parallel-out frame receiver. It is the receive end of the serial link driven by the universal shift register in load-then-shift mode. It collects WIDTH bits in either MSB-first order (producer shifting left) or LSB-first order (producer shifting right). It presents each completed word on a one-entry valid/ready output buffer, with overrun detection.

---
 rtl/serial_frame_pkg.sv | 16 +
 rtl/sipo_shift_core.sv | 36 +++
 rtl/serial_frame_rx.sv | 127 ++++++++++++
 tb/tb_serial_frame_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
// Shared types and constants for the serial frame receiver.
//   rx_state_t     : receiver FSM state (IDLE / RECV)
//   DIR_MSB_FIRST  : dir value selecting MSB-first reception (producer shifts left)
//   DIR_LSB_FIRST  : dir value selecting LSB-first reception (producer shifts right)
package serial_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core
// Direction-selectable serial-in shift register.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, clears the register
//   shift_en : shift one bit in this cycle
//   dir      : DIR_MSB_FIRST shifts left (new bit enters at bit 0),
//              DIR_LSB_FIRST shifts right (new bit enters at the MSB)
//   ser_in   : serial data bit
//   sh       : current shift register contents
module sipo_shift_core
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] sh
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (shift_en) begin
      if (dir == DIR_LSB_FIRST) begin
        sh <= {ser_in, sh[WIDTH-1:1]};
      end else begin
        sh <= {sh[WIDTH-2:0], ser_in};
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Serial-in/parallel-out frame receiver with a one-entry valid/ready output
// buffer and sticky overrun detection.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   ser_in      : serial data bit
//   ser_valid   : ser_in is meaningful this cycle
//   frame_start : current valid bit is bit 0 of a new frame
//   dir         : 0 = MSB-first, 1 = LSB-first (latched on an accepted frame_start)
//   q           : received word
//   q_valid     : q holds an unconsumed word
//   q_ready     : consumer takes q when q_valid & q_ready
//   busy        : a frame is in progress
//   overrun     : sticky, a completed frame was dropped
//   clr_overrun : synchronous clear of overrun (a coincident new overrun wins)
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             dir_lat;
  logic             start;
  logic             shift_en;
  logic             dir_eff;
  logic             done;
  logic             handshake;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] word;

  // A start bit is shifted with the freshly presented dir, not the stale latch.
  assign start     = ser_valid & frame_start;
  assign shift_en  = start | (ser_valid & (state == RECV));
  assign dir_eff   = start ? dir : dir_lat;
  assign done      = ser_valid & ~frame_start & (state == RECV) & (cnt == CW'(WIDTH - 1));
  assign handshake = q_valid & q_ready;
  assign busy      = (state == RECV);

  // The completing bit is not yet in sh, so the word is formed from sh plus
  // that bit; this lets q load on the same edge as the final bit.
  assign word = (dir_lat == DIR_LSB_FIRST) ? {ser_in, sh[WIDTH-1:1]}
                                           : {sh[WIDTH-2:0], ser_in};

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .dir      (dir_eff),
    .ser_in   (ser_in),
    .sh       (sh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RECV;
    end else if (done) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      dir_lat <= DIR_MSB_FIRST;
    end else if (start) begin
      cnt     <= CW'(1);
      dir_lat <= dir;
    end else if (done) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Output buffer: a completion either loads (buffer free or being drained
  // this cycle) or is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done && (!q_valid || q_ready)) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (handshake) begin
        q_valid <= 1'b0;
      end

      if (done && q_valid && !q_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Self-checking bench for serial_frame_rx (WIDTH=8): a table of whole frames,
// hand-written multi-cycle corner sequences, and a randomized run, all checked
// against a queue-based reference model of the receiver.
module tb_serial_frame_rx;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         ser_in;
  logic         ser_valid;
  logic         frame_start;
  logic         dir;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         overrun;
  logic         clr_overrun;

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .dir         (dir),
    .q           (q),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int qv_seen = 0;

  // Reference model state
  bit         m_bits[$];
  bit         m_busy;
  bit         m_dir;
  bit [W-1:0] m_q;
  bit         m_qv;
  bit         m_ovr;

  typedef struct {
    logic         d;
    logic [W-1:0] ser;   // ser[W-1] is transmitted first
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_busy = 0;
    m_dir  = 0;
    m_q    = '0;
    m_qv   = 0;
    m_ovr  = 0;
  endtask

  // One clock of receiver behaviour given the inputs present at the edge.
  task automatic model_step();
    bit         done;
    bit         set_ovr;
    bit [W-1:0] w;
    done    = 0;
    set_ovr = 0;
    w       = '0;
    if (ser_valid) begin
      if (frame_start) begin
        m_bits.delete();
        m_dir  = dir;
        m_bits.push_back(ser_in);
        m_busy = 1;
      end else if (m_busy) begin
        m_bits.push_back(ser_in);
        if (m_bits.size() == W) begin
          // Bit k of the frame lands at position W-1-k (MSB-first) or k (LSB-first).
          for (int i = 0; i < W; i++) begin
            if (m_dir == 0) w[W-1-i] = m_bits[i];
            else            w[i]     = m_bits[i];
          end
          done   = 1;
          m_busy = 0;
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (m_qv && !q_ready) set_ovr = 1;
      else begin
        m_q  = w;
        m_qv = 1;
      end
    end else if (m_qv && q_ready) begin
      m_qv = 0;
    end
    if (set_ovr) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (q_valid) qv_seen++;
    chk("q",       q,       m_q);
    chk("q_valid", q_valid, m_qv);
    chk("busy",    busy,    m_busy);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic idle(input int n);
    ser_valid   = 0;
    frame_start = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_frame(input logic d, input logic [W-1:0] s, input int gap_pct,
                            input logic rdy_last, input logic [W-1:0] exp);
    for (int i = 0; i < W; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        ser_valid   = 0;
        ser_in      = 1'($urandom);
        frame_start = 1'($urandom);
        dir         = 1'($urandom);
        step();
      end
      ser_valid   = 1;
      ser_in      = s[W-1-i];
      frame_start = (i == 0);
      dir         = (i == 0) ? d : 1'($urandom);
      if (i == W - 1) q_ready = rdy_last;
      step();
    end
    ser_valid   = 0;
    frame_start = 0;
    chk("frame_q", q, exp);
  endtask

  initial begin
    tbl[0] = '{d: 1'b0, ser: 8'hA5, exp: 8'hA5};
    tbl[1] = '{d: 1'b1, ser: 8'hA5, exp: 8'hA5};
    tbl[2] = '{d: 1'b0, ser: 8'h0F, exp: 8'h0F};
    tbl[3] = '{d: 1'b1, ser: 8'h0F, exp: 8'hF0};
    tbl[4] = '{d: 1'b1, ser: 8'h80, exp: 8'h01};
    tbl[5] = '{d: 1'b0, ser: 8'h80, exp: 8'h80};
    tbl[6] = '{d: 1'b1, ser: 8'hC1, exp: 8'h83};
    tbl[7] = '{d: 1'b0, ser: 8'h3C, exp: 8'h3C};

    reset = 1; ser_in = 0; ser_valid = 0; frame_start = 0; dir = 0;
    q_ready = 0; clr_overrun = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 0;
    idle(2);

    // Whole frames back to back-ish, consumer always ready.
    q_ready = 1;
    for (int t = 0; t < 8; t++) begin
      send_frame(tbl[t].d, tbl[t].ser, 0, 1'b1, tbl[t].exp);
      idle(1);
    end

    // 8'h3C MSB-first with random gaps.
    send_frame(1'b0, 8'h3C, 40, 1'b1, 8'h3C);
    idle(2);

    // Restart: three bits of a frame, then a new frame_start carrying 8'h81.
    qv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1; ser_in = 1'(i); frame_start = (i == 0); dir = 1; step();
    end
    send_frame(1'b0, 8'h81, 0, 1'b1, 8'h81);
    idle(3);
    chk("restart_pulses", qv_seen, 1);
    chk("restart_ovr", overrun, 0);

    // Overrun: buffer full, second word dropped.
    q_ready = 0;
    send_frame(1'b0, 8'h11, 0, 1'b0, 8'h11);
    send_frame(1'b0, 8'h22, 0, 1'b0, 8'h11);
    chk("ovr_set", overrun, 1);
    q_ready = 1; clr_overrun = 1; step();
    q_ready = 0; clr_overrun = 0;
    chk("drain_qv", q_valid, 0);
    chk("clr_ovr", overrun, 0);
    send_frame(1'b0, 8'h44, 0, 1'b0, 8'h44);
    send_frame(1'b0, 8'h33, 0, 1'b1, 8'h33);
    q_ready = 0;
    chk("hs_load_qv", q_valid, 1);
    chk("hs_load_ovr", overrun, 0);

    // Set wins over a coincident clear.
    clr_overrun = 1;
    send_frame(1'b1, 8'h66, 0, 1'b0, 8'h33);
    clr_overrun = 0;
    chk("set_wins", overrun, 1);
    clr_overrun = 1; step(); clr_overrun = 0;

    // Asynchronous reset mid-frame with a pending word.
    for (int i = 0; i < 5; i++) begin
      ser_valid = 1; ser_in = 1; frame_start = (i == 0); dir = 0; step();
    end
    ser_valid = 0; frame_start = 0;
    #3 reset = 1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_q_valid", q_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    model_reset();
    reset = 0;
    idle(1);
    q_ready = 1;
    send_frame(1'b0, 8'h5A, 0, 1'b1, 8'h5A);
    idle(2);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      ser_valid   = ($urandom_range(3) != 0);
      ser_in      = 1'($urandom);
      frame_start = ($urandom_range(15) == 0);
      dir         = 1'($urandom);
      q_ready     = ($urandom_range(2) != 0);
      clr_overrun = ($urandom_range(15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
